fetch_dispatch_ctrl: RTL and testbench
======================================

FETCH_DISPATCH_CTRL -- requirements
Module: fetch_dispatch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, PC loaded on reset.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, range 1..4, credit limit and response-buffer depth.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port jumpFlag_i  input  1  redirect request from execute.
REQ-006 SHALL have port jumpAddr_i  input  32  redirect target.
REQ-007 SHALL have port mem_req_o  output  1  fetch request valid.
REQ-008 SHALL have port mem_addr_o  output  32  fetch address.
REQ-009 SHALL have port mem_ready_i  input  1  memory accepts request this cycle.
REQ-010 SHALL have port mem_rvalid_i  input  1  in-order instruction return.
REQ-011 SHALL have port mem_rdata_i  input  32  returned instruction.
REQ-012 SHALL have ports way0_ready_i, way1_ready_i  input  1 each  IFU way can accept.
REQ-013 SHALL have ports way0_valid_o, way1_valid_o  output  1 each  dispatch strobe per way.
REQ-014 SHALL have ports inst_o, instAddr_o  output  32 each  shared dispatch payload.

Function
REQ-015 SHALL implement states IDLE, FETCH, FLUSH; IDLE->FETCH one cycle after reset release.
REQ-016 SHALL assert mem_req_o in FETCH only when outstanding + buffered < MAX_OUTSTANDING; mem_addr_o = PC.
REQ-017 SHALL, on mem_req_o && mem_ready_i, push PC into address FIFO, increment outstanding, PC <= PC + 4 (mod 2^32).
REQ-018 SHALL hold mem_req_o and mem_addr_o stable until accepted, except on jump.
REQ-019 SHALL, on mem_rvalid_i outside FLUSH, write {mem_rdata_i, FIFO-head address} into response buffer and decrement outstanding, same cycle.
REQ-020 SHALL steer buffer head to way given by 1-bit pointer (0=way0); strobe that way's valid only when its ready is high; toggle pointer per dispatch; max one dispatch per cycle.
REQ-021 SHALL add zero cycles of dispatch latency: a response written in cycle N is dispatchable in cycle N+1.
REQ-022 SHALL stall on the head when the target way is not ready; other way never bypasses (program order).
REQ-023 SHALL, on jumpFlag_i, same cycle: deassert mem_req_o and both valids, clear buffer and address FIFO, load PC <= jumpAddr_i, pointer <= 0, discard count <= outstanding, outstanding <= 0.
REQ-024 SHALL enter FLUSH if discard count > 0, else FETCH; in FLUSH drop each mem_rvalid_i and decrement discard; FLUSH->FETCH when count reaches 0.
REQ-025 SHALL, on jump during FLUSH, reload PC, keep discard count (plus any newly accepted), stay FLUSH.
REQ-026 SHALL treat jump coincident with mem_rvalid_i as discard (response counted in discard, not buffered).
REQ-027 SHALL accept simultaneous response write and dispatch read at full buffer without loss.
REQ-028 SHALL never overflow buffer or underflow counters; rvalid with zero outstanding is ignored.

Reset
REQ-029 SHALL, while reset high: state=IDLE, PC=RESET_PC, pointer=0, counters/FIFOs empty, mem_req_o=0, way0_valid_o=way1_valid_o=0, inst_o=instAddr_o=0.
REQ-030 SHALL on reset mid-operation abandon all in-flight requests; later returns ignored.

Configuration
REQ-031 SHALL with FETCH_PERF_CNT_EN defined add output dispatch_cnt_o (32) counting dispatches and flush_cnt_o (16) counting jumps, both cleared by reset, wrapping.
REQ-032 SHALL without FETCH_PERF_CNT_EN omit those ports and counters; function otherwise identical.

Verification
REQ-033 SHALL test reset release, mem_ready_i=1, 1-cycle return: addresses 0x80000000,0x80000004 dispatch to way0 then way1, instAddr_o matching.
REQ-034 SHALL test way1_ready_i=0 for 5 cycles: buffer fills to 2, mem_req_o drops, way0 not bypassed, resumes in order.
REQ-035 SHALL test jump to 0x1000 with 2 outstanding: both returns dropped, next dispatch instAddr_o=0x1000 on way0.
REQ-036 SHALL test jump coincident with rvalid and second jump during FLUSH: only final target's instructions dispatched.
REQ-037 SHALL test reset asserted with outstanding requests: all outputs reset values next cycle, stale rvalid ignored.
REQ-038 SHALL test with FETCH_PERF_CNT_EN: 10 dispatches, 3 jumps -> dispatch_cnt_o=10, flush_cnt_o=3.

Source files
------------

// File: rtl/fetch_dispatch_ctrl.sv
// fetch_dispatch_ctrl
//   Instruction fetch front end. Issues in-order fetch requests under a credit
//   limit, pairs each returned instruction with its fetch address, buffers the
//   pairs and dispatches them alternately to two IFU ways in program order.
//   A jump redirects the PC, empties the buffer and discards every return that
//   is still in flight (FLUSH state) before fetching resumes.
//
// Parameters
//   RESET_PC         PC loaded on reset
//   MAX_OUTSTANDING  credit limit and response-buffer depth (1..4)
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   jumpFlag_i, jumpAddr_i       redirect request and target
//   mem_req_o, mem_addr_o        fetch request / address
//   mem_ready_i                  memory accepts the request this cycle
//   mem_rvalid_i, mem_rdata_i    in-order instruction return
//   way0/1_ready_i               IFU way can accept
//   way0/1_valid_o               dispatch strobe per way
//   inst_o, instAddr_o           shared dispatch payload (zero when idle)
// Optional build macro
//   FETCH_PERF_CNT_EN  adds dispatch_cnt_o (32) and flush_cnt_o (16)
module fetch_dispatch_ctrl #(
  parameter logic [31:0] RESET_PC        = 32'h8000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jumpFlag_i,
  input  logic [31:0] jumpAddr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        way0_ready_i,
  input  logic        way1_ready_i,
  output logic        way0_valid_o,
  output logic        way1_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] instAddr_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] dispatch_cnt_o,
  output logic [15:0] flush_cnt_o
`endif
);

  localparam int CW    = 3;  // holds 0..4
  localparam int IW    = 2;
  localparam int DEPTH = 4;
  localparam logic [IW-1:0] LAST = IW'(MAX_OUTSTANDING - 1);
  localparam logic [CW:0]   MAXC = (CW+1)'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, FLUSH = 2'd2} state_e;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } resp_t;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;    // accepted, not yet returned
  logic [CW-1:0] cnt_q, cnt_d;    // buffered responses
  logic [CW-1:0] disc_q, disc_d;  // returns still to be dropped
  logic          ptr_q, ptr_d;    // target way of buffer head

  logic [31:0]   afifo_q [DEPTH];
  logic [IW-1:0] af_wr_q, af_rd_q;
  resp_t         rbuf_q [DEPTH];
  logic [IW-1:0] rb_wr_q, rb_rd_q;

  logic  req, accept, rsp_take, rsp_wr, rsp_drop, dispatch, tgt_rdy;
  resp_t head;

  // Circular index wrapping at MAX_OUTSTANDING entries.
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (i == LAST) ? '0 : i + IW'(1);
  endfunction

  always_comb begin
    tgt_rdy  = ptr_q ? way1_ready_i : way0_ready_i;
    // Credits count both in-flight and buffered entries, so a return can
    // always be written even when a dispatch is stalled.
    req      = !reset && (state_q == FETCH) && !jumpFlag_i
               && (({1'b0, out_q} + {1'b0, cnt_q}) < MAXC);
    accept   = req && mem_ready_i;
    // A return is only meaningful while something is pending; stray ones
    // (e.g. from requests abandoned by reset) are ignored.
    rsp_take = !reset && mem_rvalid_i && ((out_q != '0) || (disc_q != '0));
    rsp_wr   = rsp_take && !jumpFlag_i && (state_q != FLUSH) && (out_q != '0);
    rsp_drop = rsp_take && !rsp_wr;
    dispatch = !reset && !jumpFlag_i && (cnt_q != '0) && tgt_rdy;
    head     = rbuf_q[rb_rd_q];
  end

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q;
    cnt_d  = cnt_q;
    disc_d = disc_q;
    ptr_d  = ptr_q;
    if (jumpFlag_i) begin
      pc_d   = jumpAddr_i;
      out_d  = '0;
      cnt_d  = '0;
      ptr_d  = 1'b0;
      // Everything in flight becomes discard; a return arriving with the
      // jump is itself one of those and is consumed right now.
      disc_d = disc_q + out_q - CW'(rsp_drop);
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      out_d  = out_q + CW'(accept) - CW'(rsp_wr);
      cnt_d  = cnt_q + CW'(rsp_wr) - CW'(dispatch);
      disc_d = disc_q - CW'(rsp_drop);
      if (dispatch) ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      out_q   <= '0;
      cnt_q   <= '0;
      disc_q  <= '0;
      ptr_q   <= 1'b0;
      af_wr_q <= '0;
      af_rd_q <= '0;
      rb_wr_q <= '0;
      rb_rd_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      disc_q <= disc_d;
      ptr_q  <= ptr_d;
      if (jumpFlag_i) begin
        af_wr_q <= '0;
        af_rd_q <= '0;
        rb_wr_q <= '0;
        rb_rd_q <= '0;
      end else begin
        if (accept) af_wr_q <= nxt(af_wr_q);
        if (rsp_wr) begin
          af_rd_q <= nxt(af_rd_q);
          rb_wr_q <= nxt(rb_wr_q);
        end
        if (dispatch) rb_rd_q <= nxt(rb_rd_q);
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (accept) afifo_q[af_wr_q] <= pc_q;
    if (rsp_wr) rbuf_q[rb_wr_q]  <= '{inst: mem_rdata_i, addr: afifo_q[af_rd_q]};
  end

  // FSM: state register / next state / outputs
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         state_d = FETCH;  // nothing in flight, nothing to discard
      FETCH, FLUSH: state_d = (disc_d != '0) ? FLUSH : FETCH;
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o    = req;
    mem_addr_o   = pc_q;
    way0_valid_o = dispatch && !ptr_q;
    way1_valid_o = dispatch && ptr_q;
    inst_o       = dispatch ? head.inst : '0;
    instAddr_o   = dispatch ? head.addr : '0;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] disp_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (dispatch)   disp_cnt_q  <= disp_cnt_q + 32'd1;
      if (jumpFlag_i) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign dispatch_cnt_o = disp_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_dispatch_ctrl.sv
// Self-checking bench for fetch_dispatch_ctrl: directed scenarios followed by
// a randomized run, all checked cycle by cycle against a queue-based model.
module tb_fetch_dispatch_ctrl;
  localparam int          MAXO = 2;
  localparam logic [31:0] RPC  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset, jumpFlag_i, mem_ready_i, mem_rvalid_i;
  logic        way0_ready_i, way1_ready_i;
  logic [31:0] jumpAddr_i, mem_rdata_i;
  logic        mem_req_o, way0_valid_o, way1_valid_o;
  logic [31:0] mem_addr_o, inst_o, instAddr_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] dispatch_cnt_o;
  logic [15:0] flush_cnt_o;
`endif

  always #5 clk = ~clk;

  fetch_dispatch_ctrl #(.RESET_PC(RPC), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .jumpFlag_i(jumpFlag_i), .jumpAddr_i(jumpAddr_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .way0_ready_i(way0_ready_i), .way1_ready_i(way1_ready_i),
    .way0_valid_o(way0_valid_o), .way1_valid_o(way1_valid_o),
    .inst_o(inst_o), .instAddr_o(instAddr_o)
`ifdef FETCH_PERF_CNT_EN
    , .dispatch_cnt_o(dispatch_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  int checks = 0, failures = 0;

  typedef struct packed { logic [31:0] inst; logic [31:0] addr; } ent_t;
  typedef struct packed { logic way; logic [31:0] addr; logic [31:0] inst; } log_t;

  // Reference model: phase 0 idle, 1 fetching, 2 discarding
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_addrq[$];   // live requests awaiting return
  int          m_drop;       // returns to discard
  ent_t        m_buf[$];
  bit          m_ptr;
  int          m_dispc, m_jumpc;
  logic [31:0] mem_q[$];     // memory side: every accepted address, in order
  log_t        obs_log[$];   // observed dispatches
  logic        o_req;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check #1 later, then advance the model.
  // rvp: percent chance of a return when one is pending; negative forces a
  // stray rvalid regardless.
  task automatic step(input bit rst, input bit jmp, input logic [31:0] ja,
                      input bit mrdy, input bit w0, input bit w1, input int rvp);
    bit          rv, exp_req, exp_disp, took;
    logic [31:0] ea, ei, tmp;
    @(negedge clk);
    reset = rst; jumpFlag_i = jmp; jumpAddr_i = ja; mem_ready_i = mrdy;
    way0_ready_i = w0; way1_ready_i = w1;
    if (rvp < 0) rv = 1'b1;
    else         rv = (mem_q.size() > 0) && ($urandom_range(0, 99) < rvp);
    mem_rvalid_i = rv;
    mem_rdata_i  = (rv && mem_q.size() > 0) ? inst_of(mem_q[0]) : $urandom;
    #1;
    exp_req  = !rst && m_phase == 1 && !jmp && (m_addrq.size() + m_buf.size() < MAXO);
    exp_disp = !rst && !jmp && m_buf.size() > 0 && (m_ptr ? w1 : w0);
    ea = exp_disp ? m_buf[0].addr : 32'h0;
    ei = exp_disp ? m_buf[0].inst : 32'h0;
    chk("mem_req", 32'(mem_req_o), 32'(exp_req));
    if (exp_req) chk("mem_addr", mem_addr_o, m_pc);
    chk("way0_valid", 32'(way0_valid_o), 32'(exp_disp && !m_ptr));
    chk("way1_valid", 32'(way1_valid_o), 32'(exp_disp && m_ptr));
    chk("inst", inst_o, ei);
    chk("instAddr", instAddr_o, ea);
`ifdef FETCH_PERF_CNT_EN
    if (!rst) begin
      chk("dispatch_cnt", dispatch_cnt_o, 32'(m_dispc));
      chk("flush_cnt", 32'(flush_cnt_o), 32'(m_jumpc & 16'hFFFF));
    end
`endif
    o_req = mem_req_o;
    if (way0_valid_o || way1_valid_o) obs_log.push_back('{way1_valid_o, instAddr_o, inst_o});

    if (rst) begin
      m_phase = 0; m_pc = RPC; m_addrq.delete(); m_drop = 0; m_buf.delete();
      m_ptr = 1'b0; m_dispc = 0; m_jumpc = 0; mem_q.delete();
    end else begin
      took = rv && (m_addrq.size() + m_drop > 0);
      if (rv && mem_q.size() > 0) void'(mem_q.pop_front());
      if (jmp) begin
        m_jumpc++;
        m_drop = m_drop + m_addrq.size() - (took ? 1 : 0);
        m_addrq.delete(); m_buf.delete();
        m_pc = ja; m_ptr = 1'b0;
        m_phase = (m_drop > 0) ? 2 : 1;
      end else begin
        if (exp_disp) begin
          void'(m_buf.pop_front());
          m_ptr = ~m_ptr;
          m_dispc++;
        end
        if (took) begin
          if (m_drop > 0) m_drop--;
          else begin
            tmp = m_addrq.pop_front();
            m_buf.push_back('{mem_rdata_i, tmp});
          end
        end
        if (exp_req && mrdy) begin
          m_addrq.push_back(m_pc);
          mem_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
        if (m_phase == 0 || (m_phase == 2 && m_drop == 0)) m_phase = 1;
      end
    end
  endtask

  task automatic chk_entry(input string tag, input int idx, input logic way,
                           input logic [31:0] addr);
    chk({tag, "_present"}, 32'(obs_log.size() > idx), 32'd1);
    if (obs_log.size() > idx) begin
      chk({tag, "_way"}, 32'(obs_log[idx].way), 32'(way));
      chk({tag, "_addr"}, obs_log[idx].addr, addr);
      chk({tag, "_inst"}, obs_log[idx].inst, inst_of(addr));
    end
  endtask

  initial begin
    bit          r, j;
    logic [31:0] ja;
    int          bad, guard;
    reset = 1'b1; jumpFlag_i = 1'b0; jumpAddr_i = '0; mem_ready_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; way0_ready_i = 1'b0; way1_ready_i = 1'b0;

    // Reset state, then straight-line fetch with 1-cycle returns
    step(1, 0, 0, 1, 1, 1, 0);
    step(1, 0, 0, 1, 1, 1, 0);
    chk("rst_req", 32'(o_req), 32'd0);
    obs_log.delete();
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 1, 100);
    chk_entry("basic0", 0, 1'b0, 32'h8000_0000);
    chk_entry("basic1", 1, 1'b1, 32'h8000_0004);

    // way1 stalled for 5 cycles: no bypass, requests stop when full
    step(1, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1, 100);
    obs_log.delete();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 0, 100);
    chk("stall_no_bypass", 32'(obs_log.size()), 32'd0);
    chk("stall_req_drop", 32'(o_req), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1, 100);
    chk_entry("resume0", 0, 1'b1, 32'h8000_0004);
    chk_entry("resume1", 1, 1'b0, 32'h8000_0008);

    // Jump with two outstanding
    step(1, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1, 0);
    obs_log.delete();
    step(0, 1, 32'h0000_1000, 1, 1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 1, 100);
    chk_entry("jump0", 0, 1'b0, 32'h0000_1000);
    chk_entry("jump1", 1, 1'b1, 32'h0000_1004);

    // Jump coincident with rvalid, second jump during FLUSH
    step(1, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1, 0);
    obs_log.delete();
    step(0, 1, 32'h0000_2000, 1, 1, 1, 100);
    step(0, 1, 32'h0000_3000, 1, 1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 1, 100);
    chk_entry("jj0", 0, 1'b0, 32'h0000_3000);
    chk_entry("jj1", 1, 1'b1, 32'h0000_3004);
    bad = 0;
    foreach (obs_log[k]) if (obs_log[k].addr[31:12] != 20'h00003) bad++;
    chk("jj_only_final", 32'(bad), 32'd0);

    // Reset with requests in flight, stray return afterwards
    step(1, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1, 0);
    step(1, 0, 0, 1, 1, 1, 0);
    chk("midrst_req", 32'(o_req), 32'd0);
    obs_log.delete();
    step(0, 0, 0, 1, 1, 1, -1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 1, 100);
    chk_entry("midrst0", 0, 1'b0, 32'h8000_0000);

`ifdef FETCH_PERF_CNT_EN
    // 10 dispatches, 3 jumps
    step(1, 0, 0, 1, 1, 1, 0);
    obs_log.delete();
    for (int i = 1; i <= 8; i++)
      step(0, (i == 4 || i == 6 || i == 8), 32'h0000_4000 + 32'(i * 16), 1, 1, 1, 100);
    guard = 0;
    while (obs_log.size() < 10 && guard < 200) begin
      step(0, 0, 0, 1, 1, 1, 100);
      guard++;
    end
    chk("perf_timeout", 32'(guard < 200), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("perf_dispatch", dispatch_cnt_o, 32'd10);
    chk("perf_flush", 32'(flush_cnt_o), 32'd3);
`endif

    // Randomized traffic
    step(1, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 999) < 3);
      j  = ($urandom_range(0, 99) < 4);
      ja = $urandom & 32'hFFFF_FFFC;
      step(r, j, ja, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, 60);
    end
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1, 1, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
